// File: rtl/spi_master_engine.sv
// =============================================================================
// spi_master_engine
// -----------------------------------------------------------------------------
// SPI master transfer engine. It shifts one DATA_W-bit frame out on MOSI while
// it shifts a frame in from MISO, MSB first. The SCLK half-period, the CPOL and
// CPHA mode and the chip-select gap after each frame are programmed per frame.
// All pad outputs come from registers clocked by clk_i. SCLK is never produced
// by gating clk_i.
//
// Frame sequence:
//   IDLE -> LEAD (1 tick, CS setup) -> XFER (2*DATA_W ticks, one SCLK edge
//   each) -> TRAIL (1 tick, CS hold) -> GAP (gap+1 cycles with CS high)
//   -> IDLE
// A tick occurs every div+1 clk_i cycles. From accept to done_o, a frame
// therefore takes 1 + (div+1)*(2*DATA_W+2) cycles.
//
// Optional build macro:
//   SPI_MASTER_LOOPBACK_EN - adds input loop_i. When loop_i is 1, the receive
//                            shifter samples the engine's own MOSI instead of
//                            miso_i.
//
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   start_i    frame request, accepted only while busy_o = 0
//   data_i     TX word                          (latched on accept)
//   div_i      SCLK half-period minus 1         (latched on accept)
//   gap_i      CS-high gap minus 1              (latched on accept)
//   cpol_i     SCLK idle level (followed in IDLE, latched on accept)
//   cpha_i     0: sample on leading edge, 1: sample on trailing edge
//   miso_i     serial data from the slave
//   loop_i     (SPI_MASTER_LOOPBACK_EN only) internal loopback select
//   busy_o     high from the cycle after accept until the gap has elapsed
//   done_o     one-cycle pulse when rx_data_o carries a new word
//   rx_data_o  last received word
//   sclk_o     SPI clock
//   mosi_o     serial data to the slave
//   cs_n_o     active-low chip select
// =============================================================================
module spi_master_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              miso_i,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loop_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o
);

    localparam int EDGE_W = $clog2(2*DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_3    = EDGE_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t state;
    state_t next_state;

    // Copies of the configuration, latched when a frame is accepted.
    logic [DIV_W-1:0]  div_l;
    logic [GAP_W-1:0]  gap_l;
    logic              cpol_l;
    logic              cpha_l;

    logic [DIV_W-1:0]  tick_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_next;

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    logic tick;
    logic accept;
    logic do_edge;
    logic finish;
    logic gap_end;
    logic odd_edge;
    logic sample_now;
    logic shift_now;
    logic sample_bit;

    // MOSI is the MSB of the transmit shifter. That shifter is a register, so
    // the pin is driven straight from a flop. Reset clears the shifter, so
    // MOSI also resets to 0.
    assign mosi_o = tx_sr[DATA_W-1];

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loop_i ? tx_sr[DATA_W-1] : miso_i;
`else
    assign sample_bit = miso_i;
`endif

    // Decode SCLK edges. edge_next is the 1-based index of the edge that the
    // current tick produces. Odd indices are leading edges. With CPHA=1 the
    // MSB already sits on MOSI from accept, so the first leading edge does not
    // shift. With CPHA=0 the last trailing edge does not shift, so the last
    // bit stays on MOSI.
    always_comb begin
        tick       = (tick_cnt == '0);
        edge_next  = edge_cnt + EDGE_W'(1);
        odd_edge   = edge_next[0];
        sample_now = 1'b0;
        shift_now  = 1'b0;
        if (do_edge) begin
            if (cpha_l) begin
                sample_now = !odd_edge;
                shift_now  = odd_edge && (edge_next >= EDGE_3);
            end else begin
                sample_now = odd_edge;
                shift_now  = !odd_edge && (edge_next != LAST_EDGE);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the one-cycle strobes that drive the datapath.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        do_edge    = 1'b0;
        finish     = 1'b0;
        gap_end    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    next_state = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tick) begin
                    next_state = S_XFER;
                end
            end
            S_XFER: begin
                if (tick) begin
                    do_edge = 1'b1;
                    if (edge_next == LAST_EDGE) begin
                        next_state = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (tick) begin
                    finish     = 1'b1;
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    gap_end    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Latch the frame configuration when a frame is accepted. Inputs that
    // change during a frame have no effect until the next accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_l  <= '0;
            gap_l  <= '0;
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
        end else if (accept) begin
            div_l  <= div_i;
            gap_l  <= gap_i;
            cpol_l <= cpol_i;
            cpha_l <= cpha_i;
        end
    end

    // Timing counters. The tick counter starts at div_i on accept. It runs
    // only in the states that pace SCLK, and it reloads each time it reaches
    // 0. The edge counter stops at 2*DATA_W because XFER exits on that edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt <= '0;
            edge_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (accept) begin
                tick_cnt <= div_i;
                edge_cnt <= '0;
            end else if (state == S_LEAD || state == S_XFER || state == S_TRAIL) begin
                tick_cnt <= tick ? div_l : (tick_cnt - DIV_W'(1));
            end
            if (do_edge) begin
                edge_cnt <= edge_next;
            end
            if (finish) begin
                gap_cnt <= gap_l;
            end else if (state == S_GAP && !gap_end) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Transmit and receive shift registers. Both shift MSB first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else begin
            if (accept) begin
                tx_sr <= data_i;
            end else if (shift_now) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (sample_now) begin
                rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};
            end
        end
    end

    // Pad and handshake outputs. In IDLE, SCLK follows cpol_i so the bus
    // already idles at the right level before the next frame. After the last
    // edge, SCLK holds the latched polarity.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
            sclk_o    <= 1'b0;
            cs_n_o    <= 1'b1;
        end else begin
            done_o <= 1'b0;
            if (state == S_IDLE) begin
                sclk_o <= cpol_i;
            end else if (do_edge) begin
                sclk_o <= ~sclk_o;
            end else if (state == S_TRAIL || state == S_GAP) begin
                sclk_o <= cpol_l;
            end
            if (accept) begin
                busy_o <= 1'b1;
                cs_n_o <= 1'b0;
            end
            if (finish) begin
                cs_n_o    <= 1'b1;
                rx_data_o <= rx_sr;
                done_o    <= 1'b1;
            end
            if (gap_end) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// =============================================================================
// tb_spi_master_engine
// -----------------------------------------------------------------------------
// Directed testbench with two engine instances: an 8-bit one and a 16-bit one.
// A behavioural SPI slave model is attached to each instance. When a frame is
// started, the word the slave will return is pushed onto a per-instance
// queue. Every done_o pulse pops that queue and compares the entry with
// rx_data_o. The slave model also captures MOSI, so the transmitted word can
// be checked as well. The loopback steps are built only when
// SPI_MASTER_LOOPBACK_EN is defined.
// =============================================================================
module tb_spi_master_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic        start8, cpol8, cpha8, miso8, slave_miso8, tie_miso0;
    logic [7:0]  data8, div8, rx8;
    logic [3:0]  gap8;
    logic        busy8, done8, sclk8, mosi8, cs8;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loop8, loop16;
`endif

    // 16-bit instance
    logic        start16, cpol16, cpha16, slave_miso16;
    logic [15:0] data16, rx16;
    logic [7:0]  div16;
    logic [3:0]  gap16;
    logic        busy16, done16, sclk16, mosi16, cs16;

    assign miso8 = tie_miso0 ? 1'b0 : slave_miso8;

    // Scoreboards of expected received words
    logic [15:0] exp8_q[$];
    logic [15:0] exp16_q[$];

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic [15:0] sword8 = '0, srx8 = '0, sword16 = '0, srx16 = '0;
    int          sdi8 = 0, edges8 = 0, rises8 = 0;
    int          sdi16 = 0, edges16 = 0, viol16 = 0;
    logic        psclk8 = 1'b0, pcs8 = 1'b1;
    logic        psclk16 = 1'b0, pcs16 = 1'b1, pmosi16 = 1'b0;

    spi_master_engine #(.DATA_W(8), .DIV_W(8), .GAP_W(4)) u_dut8 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start8),
        .data_i    (data8),
        .div_i     (div8),
        .gap_i     (gap8),
        .cpol_i    (cpol8),
        .cpha_i    (cpha8),
        .miso_i    (miso8),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loop_i    (loop8),
`endif
        .busy_o    (busy8),
        .done_o    (done8),
        .rx_data_o (rx8),
        .sclk_o    (sclk8),
        .mosi_o    (mosi8),
        .cs_n_o    (cs8)
    );

    spi_master_engine #(.DATA_W(16), .DIV_W(8), .GAP_W(4)) u_dut16 (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start16),
        .data_i    (data16),
        .div_i     (div16),
        .gap_i     (gap16),
        .cpol_i    (cpol16),
        .cpha_i    (cpha16),
        .miso_i    (slave_miso16),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loop_i    (loop16),
`endif
        .busy_o    (busy16),
        .done_o    (done16),
        .rx_data_o (rx16),
        .sclk_o    (sclk16),
        .mosi_o    (mosi16),
        .cs_n_o    (cs16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one start pulse on the selected instance and queue the word the
    // slave will return. The task returns at the negedge of the cycle after
    // the accept cycle.
    task automatic applyStimulus(input bit wide, input logic [15:0] data, input logic [7:0] div,
                                 input logic [3:0] gap, input logic cpol, input logic cpha,
                                 input logic [15:0] slave_word);
        if (wide) begin
            data16 = data; div16 = div; gap16 = gap; cpol16 = cpol; cpha16 = cpha;
            sword16 = slave_word; start16 = 1'b1;
            exp16_q.push_back(slave_word);
        end else begin
            data8 = data[7:0]; div8 = div; gap8 = gap; cpol8 = cpol; cpha8 = cpha;
            sword8 = slave_word; start8 = 1'b1;
            exp8_q.push_back(slave_word);
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Count cycles until done_o, with a bound. The cycle in which start_i was
    // high is cycle 0, so on return lat is the index of the cycle with done_o.
    task automatic waitDone(input bit wide, output int lat, output int low);
        lat = 1;
        low = 0;
        while (!(wide ? done16 : done8) && lat < 3000) begin
            if (!(wide ? cs16 : cs8)) low++;
            @(negedge clk);
            lat++;
        end
        checkOutput(wide ? "done16_seen" : "done8_seen", {31'd0, wide ? done16 : done8}, 32'd1);
    endtask

    task automatic waitIdle(input bit wide);
        int n = 0;
        while ((wide ? busy16 : busy8) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(wide ? "idle16_reached" : "idle8_reached", {31'd0, wide ? busy16 : busy8}, 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard: every done_o must have a queued expectation.
    always @(negedge clk) begin
        if (done8) begin
            checkOutput("done8_expected", {31'd0, exp8_q.size() != 0}, 32'd1);
            if (exp8_q.size() != 0) checkOutput("rx8_scoreboard", {24'd0, rx8}, {16'd0, exp8_q.pop_front()});
        end
        if (done16) begin
            checkOutput("done16_expected", {31'd0, exp16_q.size() != 0}, 32'd1);
            if (exp16_q.size() != 0) checkOutput("rx16_scoreboard", {16'd0, rx16}, {16'd0, exp16_q.pop_front()});
        end
    end

    // Slave model for the 8-bit instance. It drives MISO on its shift edges,
    // captures MOSI on its sample edges, and counts SCLK edges.
    initial begin
        slave_miso8 = 1'b0;
        forever begin
            logic lead;
            @(posedge clk);
            #1;
            if (pcs8 && !cs8) begin
                sdi8 = 0; srx8 = '0; edges8 = 0; rises8 = 0;
                if (!cpha8) begin
                    slave_miso8 = sword8[7];
                    sdi8 = 1;
                end
            end else if (!cs8 && sclk8 != psclk8) begin
                edges8++;
                if (sclk8) rises8++;
                lead = (sclk8 != cpol8);
                if (lead ^ cpha8) begin
                    srx8 = {srx8[14:0], mosi8};
                end else if (sdi8 < 8) begin
                    slave_miso8 = sword8[7 - sdi8];
                    sdi8++;
                end
            end
            psclk8 = sclk8;
            pcs8   = cs8;
        end
    end

    // Slave model for the 16-bit instance. It also flags any MOSI change that
    // is not on a rising SCLK edge.
    initial begin
        slave_miso16 = 1'b0;
        forever begin
            logic lead;
            @(posedge clk);
            #1;
            if (!cs16 && !pcs16 && (mosi16 != pmosi16) && !(sclk16 && !psclk16)) viol16++;
            if (pcs16 && !cs16) begin
                sdi16 = 0; srx16 = '0; edges16 = 0;
                if (!cpha16) begin
                    slave_miso16 = sword16[15];
                    sdi16 = 1;
                end
            end else if (!cs16 && sclk16 != psclk16) begin
                edges16++;
                lead = (sclk16 != cpol16);
                if (lead ^ cpha16) begin
                    srx16 = {srx16[14:0], mosi16};
                end else if (sdi16 < 16) begin
                    slave_miso16 = sword16[15 - sdi16];
                    sdi16++;
                end
            end
            psclk16 = sclk16;
            pcs16   = cs16;
            pmosi16 = mosi16;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_timeout: observed=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int lat, low, ndone, first, second, run, minrun;
        bit seen_low;

        rst_n = 1'b0; tie_miso0 = 1'b0;
        start8 = 0; data8 = 0; div8 = 0; gap8 = 0; cpol8 = 0; cpha8 = 0;
        start16 = 0; data16 = 0; div16 = 0; gap16 = 0; cpol16 = 0; cpha16 = 0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop8 = 1'b0; loop16 = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Values while reset is held
        checkOutput("reset_busy",   {31'd0, busy8},  32'd0);
        checkOutput("reset_done",   {31'd0, done8},  32'd0);
        checkOutput("reset_rx",     {24'd0, rx8},    32'd0);
        checkOutput("reset_sclk",   {31'd0, sclk8},  32'd0);
        checkOutput("reset_mosi",   {31'd0, mosi8},  32'd0);
        checkOutput("reset_cs_n",   {31'd0, cs8},    32'd1);
        checkOutput("reset_busy16", {31'd0, busy16}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, div=0, gap=0, TX 0xA5, slave returns 0x3C
        applyStimulus(1'b0, 16'h00A5, 8'd0, 4'd0, 1'b0, 1'b0, 16'h003C);
        waitDone(1'b0, lat, low);
        checkOutput("mode0_latency",  lat, 32'd19);
        checkOutput("mode0_rises",    rises8, 32'd8);
        checkOutput("mode0_slave_rx", {16'd0, srx8}, 32'h00A5);
        checkOutput("mode0_sclk_idle", {31'd0, sclk8}, 32'd0);
        checkOutput("mode0_cs_n_high", {31'd0, cs8}, 32'd1);
        waitIdle(1'b0);

        // Mode 3, div=3, TX 0x81. Inputs are scrambled after accept.
        cpol8 = 1'b1; cpha8 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mode3_sclk_idle_high", {31'd0, sclk8}, 32'd1);
        applyStimulus(1'b0, 16'h0081, 8'd3, 4'd0, 1'b1, 1'b1, 16'h005E);
        data8 = 8'h00; div8 = 8'd0; gap8 = 4'd9;
        waitDone(1'b0, lat, low);
        checkOutput("mode3_latency",  lat, 32'd73);
        checkOutput("mode3_cs_low",   low, 32'd72);
        checkOutput("mode3_edges",    edges8, 32'd16);
        checkOutput("mode3_slave_rx", {16'd0, srx8}, 32'h0081);
        checkOutput("mode3_sclk_end_high", {31'd0, sclk8}, 32'd1);
        waitIdle(1'b0);

        // Start held high across frames with gap=5: one frame every 25 cycles
        cpol8 = 1'b0; cpha8 = 1'b0;
        repeat (2) @(negedge clk);
        data8 = 8'h3C; div8 = 8'd0; gap8 = 4'd5; sword8 = 16'h0096;
        repeat (3) exp8_q.push_back(16'h0096);
        ndone = 0; first = -1; second = -1; run = 0; minrun = 1000; seen_low = 1'b0;
        start8 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 60) start8 = 1'b0;
            if (done8) begin
                ndone++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (!cs8) begin
                if (seen_low && run > 0 && run < minrun) minrun = run;
                seen_low = 1'b1;
                run = 0;
            end else if (seen_low) begin
                run++;
            end
            @(negedge clk);
        end
        checkOutput("b2b_done_count",   ndone, 32'd3);
        checkOutput("b2b_first_done",   first, 32'd19);
        checkOutput("b2b_frame_period", second - first, 32'd25);
        checkOutput("b2b_cs_gap_ge6",   {31'd0, minrun >= 6}, 32'd1);
        waitIdle(1'b0);

        // Reset asserted at XFER edge 7
        applyStimulus(1'b0, 16'h00C3, 8'd0, 4'd0, 1'b0, 1'b0, 16'h0055);
        lat = 0;
        while (edges8 < 7 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rst_edge7_reached", edges8, 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_cs_n", {31'd0, cs8},   32'd1);
        checkOutput("rst_mid_sclk", {31'd0, sclk8}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy8}, 32'd0);
        checkOutput("rst_mid_rx",   {24'd0, rx8},   32'd0);
        exp8_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 16'h00C3, 8'd0, 4'd0, 1'b0, 1'b0, 16'h0055);
        waitDone(1'b0, lat, low);
        checkOutput("post_rst_latency",  lat, 32'd19);
        checkOutput("post_rst_slave_rx", {16'd0, srx8}, 32'h00C3);
        waitIdle(1'b0);

        // 16-bit instance, mode 1, div=1, TX 0xBEEF, slave returns 0x1234
        applyStimulus(1'b1, 16'hBEEF, 8'd1, 4'd0, 1'b0, 1'b1, 16'h1234);
        waitDone(1'b1, lat, low);
        checkOutput("w16_latency",  lat, 32'd69);
        checkOutput("w16_edges",    edges16, 32'd32);
        checkOutput("w16_mosi_rising_only", viol16, 32'd0);
        checkOutput("w16_slave_rx", {16'd0, srx16}, 32'hBEEF);
        waitIdle(1'b1);

`ifdef SPI_MASTER_LOOPBACK_EN
        // Loopback: MISO tied low, received word must equal the TX word
        tie_miso0 = 1'b1;
        loop8 = 1'b1;
        applyStimulus(1'b0, 16'h005A, 8'd0, 4'd0, 1'b0, 1'b0, 16'h005A);
        waitDone(1'b0, lat, low);
        checkOutput("loop_latency", lat, 32'd19);
        waitIdle(1'b0);
        loop8 = 1'b0;
        tie_miso0 = 1'b0;
`endif

        checkOutput("queue8_drained",  exp8_q.size(),  32'd0);
        checkOutput("queue16_drained", exp16_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
